// File: rtl/axi4_lite_slave_reg_bank.sv
// axi4_lite_slave_reg_bank
// AXI4-Lite slave endpoint: terminates AW/W/B and AR/R into a bank of
// NUM_REGS memory-mapped registers with byte-strobe writes and
// OKAY/SLVERR responses. The write and read paths are independent FSMs.
// Optional build macro: AXI4LITE_SLAVE_WAIT_STATES_EN delays the rise of
// bvalid/rvalid by WAIT_CYCLES cycles (0..15).
module axi4_lite_slave_reg_bank #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2, W_WAIT = 2'd3} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_RESP = 2'd1, R_WAIT = 2'd2} rstate_t;
`else
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_RESP = 2'd1} rstate_t;
`endif

  wstate_t                r_wstate;
  rstate_t                r_rstate;
  logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];

  logic                   r_awready, r_wready, r_aw_got, r_w_got, r_aw_err;
  logic [IDX_WIDTH-1:0]   r_aw_idx;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [STRB_WIDTH-1:0]  r_wstrb;
  logic                   r_bvalid;
  logic [1:0]             r_bresp;

  logic                   r_arready, r_rvalid;
  logic [1:0]             r_rresp;
  logic [DATA_WIDTH-1:0]  r_rdata;

`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
  logic [3:0]             r_wcnt, r_rcnt;
`endif

  // Address decode: word index is the address with byte-offset bits dropped.
  logic [ADDR_WIDTH-1:0]  w_aw_word, w_ar_word;
  logic [IDX_WIDTH-1:0]   w_aw_idx, w_ar_idx;
  logic                   w_aw_err, w_ar_err, w_aw_hs, w_w_hs, w_unused;

  assign w_aw_word = awaddr >> ADDR_LSB;
  assign w_ar_word = araddr >> ADDR_LSB;
  assign w_aw_idx  = w_aw_word[IDX_WIDTH-1:0];
  assign w_ar_idx  = w_ar_word[IDX_WIDTH-1:0];
  assign w_aw_err  = (w_aw_word >= ADDR_WIDTH'(NUM_REGS));
  assign w_ar_err  = (w_ar_word >= ADDR_WIDTH'(NUM_REGS));
  assign w_aw_hs   = awvalid && r_awready;
  assign w_w_hs    = wvalid && r_wready;
  // Protection bits carry no meaning for this endpoint.
  assign w_unused  = ^{awprot, arprot};

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_flat
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end
  endgenerate

  // Register bank: byte-strobed update during W_COMMIT, error addresses write nothing.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= {DATA_WIDTH{1'b0}};
    end else if ((r_wstate == W_COMMIT) && !r_aw_err) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (r_wstrb[b]) r_regs[r_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  // Write FSM: capture AW and W in any order, commit, then hold B until bready.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_aw_err  <= 1'b0;
      r_aw_idx  <= {IDX_WIDTH{1'b0}};
      r_wdata   <= {DATA_WIDTH{1'b0}};
      r_wstrb   <= {STRB_WIDTH{1'b0}};
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
      r_wcnt    <= 4'd0;
`endif
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_got  <= 1'b1;
            r_awready <= 1'b0;
            r_aw_idx  <= w_aw_idx;
            r_aw_err  <= w_aw_err;
          end
          if (w_w_hs) begin
            r_w_got  <= 1'b1;
            r_wready <= 1'b0;
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
          end
          if ((r_aw_got || w_aw_hs) && (r_w_got || w_w_hs)) r_wstate <= W_COMMIT;
        end
        W_COMMIT: begin
          r_aw_got <= 1'b0;
          r_w_got  <= 1'b0;
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
          if (WAIT_LOAD == 4'd0) begin
            r_bvalid <= 1'b1;
            r_bresp  <= r_aw_err ? RESP_SLVERR : RESP_OKAY;
            r_wstate <= W_RESP;
          end else begin
            r_wcnt   <= WAIT_LOAD;
            r_wstate <= W_WAIT;
          end
`else
          r_bvalid <= 1'b1;
          r_bresp  <= r_aw_err ? RESP_SLVERR : RESP_OKAY;
          r_wstate <= W_RESP;
`endif
        end
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
        W_WAIT: begin
          if (r_wcnt == 4'd1) begin
            r_wcnt   <= 4'd0;
            r_bvalid <= 1'b1;
            r_bresp  <= r_aw_err ? RESP_SLVERR : RESP_OKAY;
            r_wstate <= W_RESP;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
`endif
        W_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          r_aw_got  <= 1'b0;
          r_w_got   <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: latch data/response on the AR handshake and hold R until rready.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= {DATA_WIDTH{1'b0}};
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
      r_rcnt    <= 4'd0;
`endif
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid && r_arready) begin
            r_arready <= 1'b0;
            r_rresp   <= w_ar_err ? RESP_SLVERR : RESP_OKAY;
            r_rdata   <= w_ar_err ? {DATA_WIDTH{1'b0}} : r_regs[w_ar_idx];
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
            if (WAIT_LOAD == 4'd0) begin
              r_rvalid <= 1'b1;
              r_rstate <= R_RESP;
            end else begin
              r_rcnt   <= WAIT_LOAD;
              r_rstate <= R_WAIT;
            end
`else
            r_rvalid <= 1'b1;
            r_rstate <= R_RESP;
`endif
          end
        end
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
        R_WAIT: begin
          if (r_rcnt == 4'd1) begin
            r_rcnt   <= 4'd0;
            r_rvalid <= 1'b1;
            r_rstate <= R_RESP;
          end else begin
            r_rcnt <= r_rcnt - 4'd1;
          end
        end
`endif
        R_RESP: begin
          if (rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_rvalid  <= 1'b0;
          r_arready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_reg_bank.sv
// Self-checking bench for axi4_lite_slave_reg_bank (32-bit data, 16 registers).
// Expected values come from a register-array model updated by byte strobes.
module tb_axi4_lite_slave_reg_bank;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int WC = 3;
`ifdef AXI4LITE_SLAVE_WAIT_STATES_EN
  localparam int EXTRA = WC;
`else
  localparam int EXTRA = 0;
`endif
  localparam int WLAT = 2 + EXTRA;
  localparam int RLAT = 1 + EXTRA;

  logic aclk = 1'b0;
  logic areset;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NR*DW-1:0] reg_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] model [NR];

  axi4_lite_slave_reg_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_CYCLES(WC)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  function automatic bit addr_err(input logic [31:0] a);
    return (a / 4) >= NR;
  endfunction

  // Apply a write to the model: whole bytes chosen by strobe, errors ignored.
  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    if (!addr_err(a)) begin
      v = model[a / 4];
      for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      model[a / 4] = v;
    end
  endfunction

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int bstall, output logic [1:0] resp, output int lat,
                          output bit ready_ok, output bit stall_ok, output bit post_ok);
    bit aw_done, w_done, hs_aw, hs_w, got;
    int since, aw_start, w_start;
    aw_done = 0; w_done = 0; got = 0; since = 0; lat = -1; resp = 2'b11;
    ready_ok = 1; stall_ok = 1; post_ok = 0;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    awaddr = addr; wdata = data; wstrb = strb; bready = (bstall == 0);
    for (int n = 0; n < 40 && !got; n++) begin
      awvalid = !aw_done && (n >= aw_start);
      wvalid  = !w_done && (n >= w_start);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge aclk); #1;
      aw_done |= hs_aw;
      w_done  |= hs_w;
      if ((aw_done && awready) || (w_done && wready)) ready_ok = 0;
      if (aw_done && w_done) since++;
      if (bvalid) begin got = 1; lat = since; resp = bresp; end
    end
    awvalid = 0; wvalid = 0;
    if (got) begin
      for (int k = 0; k < bstall; k++) begin
        awvalid = 1; wvalid = 1;
        @(posedge aclk); #1;
        if (!bvalid || bresp !== resp || awready || wready) stall_ok = 0;
      end
      awvalid = 0; wvalid = 0; bready = 1;
      @(posedge aclk); #1;
      post_ok = !bvalid && awready && wready;
    end
    bready = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int rstall, output logic [31:0] data,
                         output logic [1:0] resp, output int lat, output bit stall_ok, output bit post_ok);
    bit done, hs, got;
    int since;
    done = 0; got = 0; since = 0; lat = -1; data = 32'hx; resp = 2'b11; stall_ok = 1; post_ok = 0;
    araddr = addr; rready = (rstall == 0);
    for (int n = 0; n < 40 && !got; n++) begin
      arvalid = !done;
      hs = arvalid && arready;
      @(posedge aclk); #1;
      done |= hs;
      if (done) since++;
      if (done && arready) stall_ok = 0;
      if (rvalid) begin got = 1; lat = since; data = rdata; resp = rresp; end
    end
    arvalid = 0;
    if (got) begin
      for (int k = 0; k < rstall; k++) begin
        arvalid = 1;
        @(posedge aclk); #1;
        if (!rvalid || rdata !== data || rresp !== resp || arready) stall_ok = 0;
      end
      arvalid = 0; rready = 1;
      @(posedge aclk); #1;
      post_ok = !rvalid && arready;
    end
    rready = 0;
  endtask

  task automatic test_reset();
    areset = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 3'd0; arprot = 3'd0;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    @(posedge aclk); #1;
    checks++; if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL reset_readies got=%b exp=111", {awready, wready, arready}); end
    checks++; if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin failures++; $display("FAIL reset_resp got=%b exp=000000", {bvalid, rvalid, bresp, rresp}); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (reg_out !== model_flat()) begin failures++; $display("FAIL reset_regs got=%h exp=0", reg_out); end
  endtask

  task automatic test_basic();
    logic [1:0] r; int lat; bit rok, sok, pok; logic [31:0] d;
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, r, lat, rok, sok, pok);
    model_write(32'h4, 32'hDEADBEEF, 4'hF);
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL basic_bresp got=%b exp=00", r); end
    checks++; if (lat !== WLAT) begin failures++; $display("FAIL basic_blat got=%0d exp=%0d", lat, WLAT); end
    checks++; if (pok !== 1'b1) begin failures++; $display("FAIL basic_wpost got=%b exp=1", pok); end
    checks++; if (reg_out[63:32] !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_reg1 got=%h exp=deadbeef", reg_out[63:32]); end
    checks++; if (reg_out !== model_flat()) begin failures++; $display("FAIL basic_regs got=%h exp=%h", reg_out, model_flat()); end
    do_read(32'h4, 0, d, r, lat, sok, pok);
    checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rdata got=%h exp=deadbeef", d); end
    checks++; if (r !== 2'b00) begin failures++; $display("FAIL basic_rresp got=%b exp=00", r); end
    checks++; if (lat !== RLAT) begin failures++; $display("FAIL basic_rlat got=%0d exp=%0d", lat, RLAT); end
    checks++; if (pok !== 1'b1) begin failures++; $display("FAIL basic_rpost got=%b exp=1", pok); end
  endtask

  task automatic test_order();
    logic [1:0] r; int lat; bit rok, sok, pok;
    do_write(32'h0, 32'hFFFFFFFF, 4'hF, 0, 0, r, lat, rok, sok, pok);
    model_write(32'h0, 32'hFFFFFFFF, 4'hF);
    do_write(32'h0, 32'h1234ABCD, 4'h3, 3, 0, r, lat, rok, sok, pok);
    model_write(32'h0, 32'h1234ABCD, 4'h3);
    checks++; if (reg_out[31:0] !== 32'hFFFFABCD) begin failures++; $display("FAIL wfirst_reg0 got=%h exp=ffffabcd", reg_out[31:0]); end
    checks++; if (rok !== 1'b1) begin failures++; $display("FAIL wfirst_wready_low got=%b exp=1", rok); end
    checks++; if (lat !== WLAT || r !== 2'b00) begin failures++; $display("FAIL wfirst_resp got=%0d/%b exp=%0d/00", lat, r, WLAT); end
    do_write(32'h1C, 32'hA5A5C3C3, 4'hC, -2, 0, r, lat, rok, sok, pok);
    model_write(32'h1C, 32'hA5A5C3C3, 4'hC);
    checks++; if (reg_out !== model_flat()) begin failures++; $display("FAIL awfirst_regs got=%h exp=%h", reg_out, model_flat()); end
    checks++; if (rok !== 1'b1 || lat !== WLAT) begin failures++; $display("FAIL awfirst_timing got=%b/%0d exp=1/%0d", rok, lat, WLAT); end
  endtask

  task automatic test_error();
    logic [1:0] r; int lat; bit rok, sok, pok; logic [31:0] d;
    do_write(32'h40, 32'h55555555, 4'hF, 0, 0, r, lat, rok, sok, pok);
    checks++; if (r !== 2'b10) begin failures++; $display("FAIL err_bresp got=%b exp=10", r); end
    checks++; if (reg_out !== model_flat()) begin failures++; $display("FAIL err_nowrite got=%h exp=%h", reg_out, model_flat()); end
    do_read(32'h40, 0, d, r, lat, sok, pok);
    checks++; if (r !== 2'b10 || d !== 32'h0) begin failures++; $display("FAIL err_read got=%b/%h exp=10/00000000", r, d); end
    do_write(32'h3C, 32'h0F0F0F0F, 4'hF, 0, 0, r, lat, rok, sok, pok);
    model_write(32'h3C, 32'h0F0F0F0F, 4'hF);
    checks++; if (r !== 2'b00 || reg_out !== model_flat()) begin failures++; $display("FAIL last_reg got=%b exp=00", r); end
    do_write(32'h3C, 32'hFFFFFFFF, 4'h0, 0, 0, r, lat, rok, sok, pok);
    checks++; if (r !== 2'b00 || reg_out !== model_flat()) begin failures++; $display("FAIL zero_strb got=%b exp=00 regs_equal=%b", r, reg_out === model_flat()); end
    do_read(32'h7, 0, d, r, lat, sok, pok);
    checks++; if (d !== model[1] || r !== 2'b00) begin failures++; $display("FAIL unaligned_read got=%h exp=%h", d, model[1]); end
  endtask

  task automatic test_backpressure();
    logic [1:0] r; int lat; bit rok, sok, pok; logic [31:0] d;
    do_write(32'h24, 32'h600DCAFE, 4'hF, 0, 5, r, lat, rok, sok, pok);
    model_write(32'h24, 32'h600DCAFE, 4'hF);
    checks++; if (sok !== 1'b1) begin failures++; $display("FAIL bstall_stable got=%b exp=1", sok); end
    checks++; if (pok !== 1'b1 || reg_out !== model_flat()) begin failures++; $display("FAIL bstall_post got=%b exp=1", pok); end
    do_read(32'h24, 5, d, r, lat, sok, pok);
    checks++; if (sok !== 1'b1) begin failures++; $display("FAIL rstall_stable got=%b exp=1", sok); end
    checks++; if (d !== 32'h600DCAFE || pok !== 1'b1) begin failures++; $display("FAIL rstall_data got=%h exp=600dcafe", d); end
  endtask

  task automatic test_collision();
    logic [1:0] r; int lat; bit rok, sok, pok, rseen, bseen; logic [31:0] old_v, got_d; logic [1:0] got_b;
    do_write(32'h14, 32'h11112222, 4'hF, 0, 0, r, lat, rok, sok, pok);
    model_write(32'h14, 32'h11112222, 4'hF);
    old_v = model[5]; got_d = 32'hx; got_b = 2'bxx;
    awaddr = 32'h14; wdata = 32'h99998888; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1; rready = 1;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; araddr = 32'h14; arvalid = 1;
    @(posedge aclk); #1;
    arvalid = 0; rseen = 0; bseen = 0;
    for (int n = 0; n < 20 && !(rseen && bseen); n++) begin
      if (rvalid && !rseen) begin rseen = 1; got_d = rdata; end
      if (bvalid && !bseen) begin bseen = 1; got_b = bresp; end
      @(posedge aclk); #1;
    end
    bready = 0; rready = 0;
    model_write(32'h14, 32'h99998888, 4'hF);
    checks++; if (got_d !== old_v) begin failures++; $display("FAIL collide_old got=%h exp=%h", got_d, old_v); end
    checks++; if (got_b !== 2'b00) begin failures++; $display("FAIL collide_bresp got=%b exp=00", got_b); end
    checks++; if (reg_out !== model_flat()) begin failures++; $display("FAIL collide_regs got=%h exp=%h", reg_out, model_flat()); end
    @(posedge aclk); #1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; int lat, c0; bit rok, sok, pok;
    for (int k = 0; k < 2; k++) begin
      c0 = cyc;
      do_write(32'h30 + 32'(k * 4), 32'hB0B0_0000 + 32'(k), 4'hF, 0, 0, r, lat, rok, sok, pok);
      model_write(32'h30 + 32'(k * 4), 32'hB0B0_0000 + 32'(k), 4'hF);
      checks++; if (cyc - c0 !== 3 + EXTRA) begin failures++; $display("FAIL b2b_cycles got=%0d exp=%0d", cyc - c0, 3 + EXTRA); end
    end
    checks++; if (reg_out !== model_flat()) begin failures++; $display("FAIL b2b_regs got=%h exp=%h", reg_out, model_flat()); end
  endtask

  task automatic test_random();
    logic [1:0] r; int lat, lead; bit rok, sok, pok; logic [31:0] a, d, q; logic [3:0] s;
    for (int it = 0; it < 30; it++) begin
      a = 32'($urandom_range(0, 19)) * 32'd4 + 32'($urandom_range(0, 3));
      d = $urandom; s = 4'($urandom_range(0, 15));
      lead = int'($urandom_range(0, 4)) - 2;
      do_write(a, d, s, lead, 0, r, lat, rok, sok, pok);
      model_write(a, d, s);
      checks++; if (r !== (addr_err(a) ? 2'b10 : 2'b00) || lat !== WLAT) begin failures++; $display("FAIL rand_write a=%h got=%b/%0d exp_err=%b lat=%0d", a, r, lat, addr_err(a), WLAT); end
      checks++; if (reg_out !== model_flat()) begin failures++; $display("FAIL rand_regs a=%h got=%h exp=%h", a, reg_out, model_flat()); end
      a = 32'($urandom_range(0, 19)) * 32'd4 + 32'($urandom_range(0, 3));
      do_read(a, 0, q, r, lat, sok, pok);
      checks++; if (q !== (addr_err(a) ? 32'h0 : model[a / 4]) || r !== (addr_err(a) ? 2'b10 : 2'b00) || lat !== RLAT) begin
        failures++; $display("FAIL rand_read a=%h got=%h/%b/%0d", a, q, r, lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    awaddr = 32'hC; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0; rready = 0;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; araddr = 32'h8; arvalid = 1;
    @(posedge aclk); #1;
    arvalid = 0; n = 0;
    while (!(bvalid && rvalid) && n < 20) begin @(posedge aclk); #1; n++; end
    checks++; if (!(bvalid && rvalid)) begin failures++; $display("FAIL rstmid_reach got=%b%b exp=11", bvalid, rvalid); end
    areset = 1; #1;
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
    checks++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin failures++; $display("FAIL rstmid_valids got=%b%b exp=00", bvalid, rvalid); end
    checks++; if (reg_out !== model_flat()) begin failures++; $display("FAIL rstmid_regs got=%h exp=0", reg_out); end
    @(posedge aclk); #1 areset = 0;
    @(posedge aclk); #1;
    checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin failures++; $display("FAIL rstmid_post got=%b exp=11100", {awready, wready, arready, bvalid, rvalid}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_error();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_basic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
